// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: D/E/M stage hazard info in, pipeline-register controls out.
interface hazard_ctrl_if;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic        d_uses_rs;
  logic        d_uses_rt;
  logic [1:0]  d_tuse_rs;
  logic [1:0]  d_tuse_rt;
  logic        d_is_md;
  logic [4:0]  e_wa;
  logic [1:0]  e_tnew;
  logic [4:0]  m_wa;
  logic [1:0]  m_tnew;
  logic        e_md_start;
  logic        e_md_is_div;
  logic        ext_stall;
  logic        pc_we;
  logic        d_we;
  logic        e_clr;
  logic        e_we;
  logic        m_we;
  logic        w_we;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output d_rs, d_rt, d_uses_rs, d_uses_rt, d_tuse_rs, d_tuse_rt, d_is_md,
           e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_is_div, ext_stall,
    input  pc_we, d_we, e_clr, e_we, m_we, w_we, md_busy, stall_cnt
  );

  modport slave (
    input  d_rs, d_rt, d_uses_rs, d_uses_rt, d_tuse_rs, d_tuse_rt, d_is_md,
           e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_is_div, ext_stall,
    output pc_we, d_we, e_clr, e_we, m_we, w_we, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: Tuse/Tnew data hazards, MD unit busy tracking,
// external freeze, and a stall performance counter.
module hazard_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);
  localparam int unsigned SC_W = 32;

  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] md_cnt_nxt;
  logic [SC_W-1:0]  stall_cnt;
  logic [SC_W-1:0]  stall_cnt_nxt;
  logic             rs_haz;
  logic             rt_haz;
  logic             md_stall;
  logic             stall;
  logic             md_busy;

  // Producer still further from result than consumer can wait; $0 and Tnew=0 never stall.
  always_comb begin
    rs_haz = 1'b0;
    rt_haz = 1'b0;
    if (hz.d_uses_rs && (hz.d_rs != 5'd0))
      rs_haz = ((hz.d_rs == hz.e_wa) && (hz.e_tnew > hz.d_tuse_rs)) ||
               ((hz.d_rs == hz.m_wa) && (hz.m_tnew > hz.d_tuse_rs));
    if (hz.d_uses_rt && (hz.d_rt != 5'd0))
      rt_haz = ((hz.d_rt == hz.e_wa) && (hz.e_tnew > hz.d_tuse_rt)) ||
               ((hz.d_rt == hz.m_wa) && (hz.m_tnew > hz.d_tuse_rt));
  end

  assign md_busy  = (md_cnt != '0);
  assign md_stall = hz.d_is_md && (md_busy || hz.e_md_start);
  assign stall    = rs_haz || rt_haz || md_stall;

  // A start only counts on an unfrozen edge, since only then does E advance past it.
  always_comb begin
    md_cnt_nxt    = md_cnt;
    stall_cnt_nxt = stall_cnt;
    if (hz.e_md_start && !hz.ext_stall)
      md_cnt_nxt = hz.e_md_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    else if (md_busy)
      md_cnt_nxt = md_cnt - CNT_W'(1);
    if (stall && !hz.ext_stall)
      stall_cnt_nxt = stall_cnt + SC_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      md_cnt    <= md_cnt_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  // Freeze overrides stall: nothing moves and no bubble is injected.
  always_comb begin
    hz.pc_we = 1'b0;
    hz.d_we  = 1'b0;
    hz.e_clr = 1'b0;
    hz.e_we  = 1'b0;
    hz.m_we  = 1'b0;
    hz.w_we  = 1'b0;
    if (reset && !hz.ext_stall) begin
      hz.pc_we = !stall;
      hz.d_we  = !stall;
      hz.e_clr = stall;
      hz.e_we  = 1'b1;
      hz.m_we  = 1'b1;
      hz.w_we  = 1'b1;
    end
  end

  assign hz.md_busy   = md_busy;
  assign hz.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: data hazards, MD busy timing, freeze and async reset.
module tb_hazard_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   exp_sc;
  int   n;

  hazard_ctrl_if hz ();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.d_rs = 5'd0;  hz.d_rt = 5'd0;
    hz.d_uses_rs = 1'b0; hz.d_uses_rt = 1'b0;
    hz.d_tuse_rs = 2'd0; hz.d_tuse_rt = 2'd0;
    hz.d_is_md = 1'b0;
    hz.e_wa = 5'd0; hz.e_tnew = 2'd0;
    hz.m_wa = 5'd0; hz.m_tnew = 2'd0;
    hz.e_md_start = 1'b0; hz.e_md_is_div = 1'b0;
    hz.ext_stall = 1'b0;
  endtask

  // Counts cycles with md_busy high; stalled counts whether D is blocked throughout.
  task automatic count_busy(input string tag, input bit stalled, output int cnt);
    cnt = 0;
    while (hz.md_busy === 1'b1 && cnt < 20) begin
      if (stalled) begin
        check({tag, "_pc_we_busy"}, 32'(hz.pc_we), 32'd0);
        exp_sc++;
      end
      cnt++;
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_sc = 0;
    idle();
    reset = 1'b0;
    #12;
    check("rst_pc_we", 32'(hz.pc_we), 32'd0);
    check("rst_e_we", 32'(hz.e_we), 32'd0);
    check("rst_busy", 32'(hz.md_busy), 32'd0);
    check("rst_stall_cnt", hz.stall_cnt, 32'd0);
    reset = 1'b1;
    tick();

    // lw $1 in E, add reading $1 in D
    hz.e_wa = 5'd1; hz.e_tnew = 2'd2;
    hz.d_rs = 5'd1; hz.d_uses_rs = 1'b1; hz.d_tuse_rs = 2'd1;
    #1;
    check("lw_pc_we", 32'(hz.pc_we), 32'd0);
    check("lw_d_we", 32'(hz.d_we), 32'd0);
    check("lw_e_clr", 32'(hz.e_clr), 32'd1);
    check("lw_e_we", 32'(hz.e_we), 32'd1);
    exp_sc++;
    tick();
    check("lw_stall_cnt", hz.stall_cnt, 32'(exp_sc));
    hz.e_wa = 5'd7; hz.e_tnew = 2'd0;
    hz.m_wa = 5'd1; hz.m_tnew = 2'd1;
    #1;
    check("lw_m_pc_we", 32'(hz.pc_we), 32'd1);
    check("lw_m_e_clr", 32'(hz.e_clr), 32'd0);
    tick();
    check("lw_m_stall_cnt", hz.stall_cnt, 32'(exp_sc));

    // rt hazard against M with Tuse 0
    idle();
    hz.d_rt = 5'd3; hz.d_uses_rt = 1'b1; hz.d_tuse_rt = 2'd0;
    hz.m_wa = 5'd3; hz.m_tnew = 2'd1;
    #1;
    check("rt_m_d_we", 32'(hz.d_we), 32'd0);
    exp_sc++;
    tick();

    // $0, Tnew=0 and unused-operand matches never stall
    idle();
    hz.e_wa = 5'd0; hz.e_tnew = 2'd2; hz.d_rs = 5'd0; hz.d_uses_rs = 1'b1;
    #1;
    check("zero_pc_we", 32'(hz.pc_we), 32'd1);
    hz.e_wa = 5'd5; hz.e_tnew = 2'd0; hz.d_rs = 5'd5;
    #1;
    check("tnew0_pc_we", 32'(hz.pc_we), 32'd1);
    hz.e_tnew = 2'd2; hz.d_uses_rs = 1'b0;
    #1;
    check("unused_pc_we", 32'(hz.pc_we), 32'd1);
    tick();
    check("nohaz_stall_cnt", hz.stall_cnt, 32'(exp_sc));

    // div then mflo
    idle();
    hz.d_is_md = 1'b1; hz.e_md_start = 1'b1; hz.e_md_is_div = 1'b1;
    #1;
    check("div_start_pc_we", 32'(hz.pc_we), 32'd0);
    check("div_start_busy", 32'(hz.md_busy), 32'd0);
    exp_sc++;
    tick();
    hz.e_md_start = 1'b0;
    count_busy("div", 1'b1, n);
    check("div_busy_len", 32'(n), 32'd10);
    check("div_done_pc_we", 32'(hz.pc_we), 32'd1);

    // mult then mflo
    hz.e_md_start = 1'b1; hz.e_md_is_div = 1'b0;
    exp_sc++;
    tick();
    hz.e_md_start = 1'b0;
    count_busy("mult", 1'b1, n);
    check("mult_busy_len", 32'(n), 32'd5);
    check("mult_done_pc_we", 32'(hz.pc_we), 32'd1);
    check("md_stall_cnt", hz.stall_cnt, 32'(exp_sc));

    // freeze during a data hazard while the MD counter runs down from 7
    idle();
    hz.e_md_start = 1'b1; hz.e_md_is_div = 1'b1;
    tick();
    hz.e_md_start = 1'b0;
    tick(); tick(); tick();
    hz.ext_stall = 1'b1;
    hz.e_wa = 5'd1; hz.e_tnew = 2'd2; hz.d_rs = 5'd1; hz.d_uses_rs = 1'b1;
    #1;
    check("frz_pc_we", 32'(hz.pc_we), 32'd0);
    check("frz_d_we", 32'(hz.d_we), 32'd0);
    check("frz_e_clr", 32'(hz.e_clr), 32'd0);
    check("frz_e_we", 32'(hz.e_we), 32'd0);
    check("frz_m_we", 32'(hz.m_we), 32'd0);
    check("frz_w_we", 32'(hz.w_we), 32'd0);
    tick(); tick(); tick();
    check("frz_stall_cnt", hz.stall_cnt, 32'(exp_sc));
    idle();
    #1;
    count_busy("frz", 1'b0, n);
    check("frz_busy_left", 32'(n), 32'd4);

    // start held under freeze loads only once unfrozen
    hz.ext_stall = 1'b1; hz.e_md_start = 1'b1; hz.e_md_is_div = 1'b0;
    tick(); tick();
    check("held_busy_frozen", 32'(hz.md_busy), 32'd0);
    hz.ext_stall = 1'b0;
    #1;
    check("held_busy_pre", 32'(hz.md_busy), 32'd0);
    tick();
    hz.e_md_start = 1'b0;
    count_busy("held", 1'b0, n);
    check("held_busy_len", 32'(n), 32'd5);

    // reload while md_cnt=3
    hz.e_md_start = 1'b1; hz.e_md_is_div = 1'b0;
    tick();
    hz.e_md_start = 1'b0;
    tick(); tick();
    hz.e_md_start = 1'b1;
    tick();
    hz.e_md_start = 1'b0;
    count_busy("reload", 1'b0, n);
    check("reload_busy_len", 32'(n), 32'd5);

    // async reset mid-division with md_cnt=6
    hz.e_md_start = 1'b1; hz.e_md_is_div = 1'b1;
    tick();
    hz.e_md_start = 1'b0;
    tick(); tick(); tick(); tick();
    check("pre_rst_busy", 32'(hz.md_busy), 32'd1);
    check("pre_rst_stall_cnt", hz.stall_cnt, 32'(exp_sc));
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", 32'(hz.md_busy), 32'd0);
    check("arst_stall_cnt", hz.stall_cnt, 32'd0);
    check("arst_pc_we", 32'(hz.pc_we), 32'd0);
    check("arst_w_we", 32'(hz.w_we), 32'd0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("rel_pc_we", 32'(hz.pc_we), 32'd1);
    check("rel_e_we", 32'(hz.e_we), 32'd1);
    tick();
    check("rel_busy", 32'(hz.md_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
